// File: rtl/uart_rx_frame.sv
// Purpose : 8N1 (8E1 with UART_RX_PARITY_EN) UART receiver with oversampled mid-bit sampling.
// Latency : rxValid is a registered pulse one clk after the mid-stop-bit sample (~9.5 bit times + 3 clk from the falling edge).
// Backpr. : none; the consumer must take rxByte on rxValid, rxByte holds until the next good frame.
//
// Ports: clk/rst (sync, active-high); rxData async serial in (idle 1);
//        rxByte last good byte; rxValid / rxFrameErr one-cycle pulses; rxBusy high outside IDLE.
// Optional: define UART_RX_PARITY_EN for even parity and the rxParityErr pulse output.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxData,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       rxFrameErr,
    output logic       rxBusy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rxParityErr
`endif
);

    localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          rx_s_q, rx_s_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          tick;
`ifdef UART_RX_PARITY_EN
    logic          parity_bit_q, parity_bit_d;
    logic          parity_err_q, parity_err_d;
`endif

    always_comb begin
        sync1_d     = rxData;
        rx_s_d      = sync1_q;
        tick        = (tick_cnt_q == TICK_LAST);
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        samp_cnt_d  = samp_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        state_d     = state_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // Restart the tick phase on the falling edge so mid-bit samples stay centred.
                if (!rx_s_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    samp_cnt_d = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (samp_cnt_q == HALF_LAST) begin
                        samp_cnt_d = '0;
                        bit_idx_d  = '0;
                        // A line already back high at mid start bit was a glitch.
                        state_d    = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (samp_cnt_q == FULL_LAST) begin
                        samp_cnt_d         = '0;
                        shift_d[bit_idx_q] = rx_s_q;
                        bit_idx_d          = bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (samp_cnt_q == FULL_LAST) begin
                        samp_cnt_d   = '0;
                        parity_bit_d = rx_s_q;
                        state_d      = S_STOP;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (samp_cnt_q == FULL_LAST) begin
                        samp_cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            // Even parity: data XOR parity must be 0.
                            if (^{shift_q, parity_bit_q}) begin
                                parity_err_d = 1'b1;
                            end else begin
                                rx_byte_d  = shift_q;
                                rx_valid_d = 1'b1;
                            end
`else
                            rx_byte_d  = shift_q;
                            rx_valid_d = 1'b1;
`endif
                        end else begin
                            // Bad stop bit wins over any parity result.
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                // Hold here while the line stays low so a break reports only once.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= parity_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rxByte     = rx_byte_q;
    assign rxValid    = rx_valid_q;
    assign rxFrameErr = frame_err_q;
    assign rxBusy     = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rxParityErr = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Purpose : randomized bench for uart_rx_frame against a frame-level reference model.
// Latency : expects the result pulse ~9.5 bit times after the start edge (window of +/-2 clk).
// Backpr. : none; the bench only observes pulses and the held rxByte.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int CLK_HZ  = 1600000;
    localparam int BAUD    = 10000;
    localparam int OS      = 16;
    localparam int BIT_CLK = CLK_HZ / BAUD;   // 160 clk per bit
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
    localparam int NBITS   = 11;
`else
    localparam bit PAR_EN  = 1'b0;
    localparam int NBITS   = 10;
`endif
    // Mid stop bit measured from the start edge, plus synchroniser and output register.
    localparam int LAT_NOM = (NBITS - 1) * BIT_CLK + BIT_CLK / 2 + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxData;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       rxFrameErr;
    logic       rxBusy;
    logic       perr_sig;
    int         cyc = 0;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: expected result events and the byte rxByte must hold.
    int         exp_kind[$];   // 1 = good byte, 2 = framing error, 3 = parity error
    int         exp_byte[$];
    int         exp_start[$];
    int         got_kind[$];
    int         got_byte[$];
    int         got_cyc[$];
    logic [7:0] model_byte = 8'h00;

    uart_rx_frame #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxData     (rxData),
        .rxByte     (rxByte),
        .rxValid    (rxValid),
        .rxFrameErr (rxFrameErr),
        .rxBusy     (rxBusy)
`ifdef UART_RX_PARITY_EN
        ,
        .rxParityErr(perr_sig)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign perr_sig = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Record every result pulse seen on the outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (rxValid || rxFrameErr || perr_sig)
                chk("strobe_exclusive", int'(rxValid) + int'(rxFrameErr) + int'(perr_sig), 1);
            if (rxValid) begin
                got_kind.push_back(1); got_byte.push_back(int'(rxByte)); got_cyc.push_back(cyc);
            end
            if (rxFrameErr) begin
                got_kind.push_back(2); got_byte.push_back(0); got_cyc.push_back(cyc);
            end
            if (perr_sig) begin
                got_kind.push_back(3); got_byte.push_back(0); got_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        rxData = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_low(input int n);
        rxData = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Serialise one frame LSB first; abort_bit >= 0 pulses rst halfway through that
    // data bit and the transmitter drops back to idle at the same moment.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic par_flip, input int abort_bit);
        logic bitq[$];
        int   start;
        bitq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
        bitq.push_back((^b) ^ par_flip);
`endif
        bitq.push_back(stop_bit);
        start = cyc;
        for (int i = 0; i < bitq.size(); i++) begin
            rxData = bitq[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                repeat (BIT_CLK / 2) @(negedge clk);
                rst    = 1'b1;
                rxData = 1'b1;
                @(negedge clk);
                rst        = 1'b0;
                model_byte = 8'h00;
                return;
            end
            repeat (BIT_CLK) @(negedge clk);
        end
        if (!stop_bit) begin
            exp_kind.push_back(2); exp_byte.push_back(0);
        end else if (PAR_EN && par_flip) begin
            exp_kind.push_back(3); exp_byte.push_back(0);
        end else begin
            exp_kind.push_back(1); exp_byte.push_back(int'(b));
            model_byte = b;
        end
        exp_start.push_back(start);
    endtask

    task automatic check_events();
        int n;
        int lat;
        chk("event_count", got_kind.size(), exp_kind.size());
        n = (got_kind.size() < exp_kind.size()) ? got_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            chk("event_kind", got_kind[i], exp_kind[i]);
            if (exp_kind[i] == 1) chk("event_byte", got_byte[i], exp_byte[i]);
            lat = got_cyc[i] - exp_start[i];
            chk("event_latency_in_window", (lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2), 1);
        end
        got_kind.delete(); got_byte.delete(); got_cyc.delete();
        exp_kind.delete(); exp_byte.delete(); exp_start.delete();
        chk("rxByte_hold", rxByte, model_byte);
    endtask

    // Short low pulse: must be rejected and the receiver must fall back to idle.
    task automatic glitch(input int len);
        logic cleared;
        hold_low(len);
        rxData = 1'b1;
        chk("glitch_busy_set", rxBusy, 1'b1);
        cleared = 1'b0;
        for (int k = len; k < 100; k++) begin
            if (!rxBusy) begin
                cleared = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("glitch_busy_clear", cleared, 1'b1);
        idle(60);
    endtask

    initial begin
        logic [7:0] b;
        logic       bad;
        logic       pf;
        rst    = 1'b1;
        rxData = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("reset_rxByte", rxByte, 8'h00);
        chk("reset_rxValid", rxValid, 1'b0);
        chk("reset_rxFrameErr", rxFrameErr, 1'b0);
        chk("reset_rxBusy", rxBusy, 1'b0);
        idle(20);

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(40);
        check_events();

        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        idle(40);
        check_events();

        glitch(40);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        idle(40);
        check_events();

        send_frame(8'h55, 1'b0, 1'b0, -1);
        hold_low(3 * BIT_CLK);
        idle(BIT_CLK);
        check_events();
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(40);
        check_events();

        send_frame(8'hC3, 1'b1, 1'b0, 4);
        chk("midrst_rxByte", rxByte, 8'h00);
        chk("midrst_rxValid", rxValid, 1'b0);
        chk("midrst_rxFrameErr", rxFrameErr, 1'b0);
        chk("midrst_rxBusy", rxBusy, 1'b0);
        idle(2 * BIT_CLK);
        check_events();
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        idle(40);
        check_events();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1, -1);
        idle(40);
        check_events();
        send_frame(8'h03, 1'b1, 1'b0, -1);
        idle(40);
        check_events();
`endif

        for (int f = 0; f < 14; f++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            pf  = PAR_EN ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            if ($urandom_range(0, 3) == 0) glitch($urandom_range(10, 60));
            send_frame(b, !bad, pf, -1);
            if (bad) begin
                hold_low($urandom_range(0, 2 * BIT_CLK));
                idle(BIT_CLK / 2);
            end else begin
                idle($urandom_range(0, 200));
            end
            check_events();
        end

        idle(20);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
